bias_add_relu_pipe: RTL and testbench

//   Consumer side of the per-layer BIAS_layerX_Y_Z constant banks. Takes one beat of N_adder_tree
//   18-bit signed adder-tree sums plus the matching packed bias vector, adds them lane-wise,

---
 rtl/bias_add_relu_pipe.sv | 113 +++++++++++
 tb/tb_bias_add_relu_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_relu_pipe.sv
// Lane-wise bias add with saturation and optional ReLU, behind a 2-stage
// valid/ready pipeline that also counts output beats and marks frame ends.
module bias_add_relu_pipe #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int RELU_EN      = 1,
    parameter int FRAME_BEATS  = 196
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_sum,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [N_adder_tree-1:0]        out_sat,
    output logic                           out_last
);

    localparam int SW = DATA_W + 1;
    localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CW-1:0]     LAST_BEAT = CW'(FRAME_BEATS - 1);
    localparam logic [DATA_W-1:0] MAX_V     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V     = {1'b1, {(DATA_W-1){1'b0}}};

    logic                           s1_valid;
    logic [N_adder_tree*SW-1:0]     s1_sum;
    logic [N_adder_tree*SW-1:0]     sum_nxt;
    logic [N_adder_tree*DATA_W-1:0] data_nxt;
    logic [N_adder_tree-1:0]        sat_nxt;
    logic                           s1_adv;
    logic                           in_xfer;
    logic                           out_xfer;
    logic [CW-1:0]                  beat_cnt;
    logic [SW-1:0]                  lane_sum;
    logic                           lane_ovf;
    logic [DATA_W-1:0]              lane_res;

    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s1_adv;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_last = out_valid & (beat_cnt == LAST_BEAT);

    always_comb begin
        sum_nxt = '0;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            sum_nxt[i*SW +: SW] = {in_sum[i*DATA_W + DATA_W - 1], in_sum[i*DATA_W +: DATA_W]}
                                + {bias[i*DATA_W + DATA_W - 1], bias[i*DATA_W +: DATA_W]};
        end
    end

    // Overflow of the DATA_W+1 sum shows up as its top two bits disagreeing.
    always_comb begin
        data_nxt = '0;
        sat_nxt  = '0;
        lane_sum = '0;
        lane_ovf = 1'b0;
        lane_res = '0;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            lane_sum = s1_sum[i*SW +: SW];
            lane_ovf = lane_sum[SW-1] ^ lane_sum[SW-2];
            if (lane_ovf)
                lane_res = lane_sum[SW-1] ? MIN_V : MAX_V;
            else
                lane_res = lane_sum[DATA_W-1:0];
            if ((RELU_EN != 0) && lane_res[DATA_W-1])
                lane_res = '0;
            data_nxt[i*DATA_W +: DATA_W] = lane_res;
            sat_nxt[i]                   = lane_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_sum   <= sum_nxt;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_data  <= data_nxt;
                out_sat   <= sat_nxt;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt <= '0;
        else if (out_xfer)
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
    end

endmodule

// File: tb/tb_bias_add_relu_pipe.sv
// Bench for bias_add_relu_pipe: two instances (ReLU on / frame of 4, ReLU off / frame of 1)
// driven identically and checked against a queue-based behavioural model.
module tb_bias_add_relu_pipe;

    localparam int NL   = 4;
    localparam int DW   = 18;
    localparam int W    = NL * DW;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] b;
        int           acc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_sum;
    logic [W-1:0]  bias;
    logic          out_ready;
    logic          a_in_ready, a_out_valid, a_out_last;
    logic [W-1:0]  a_out_data;
    logic [NL-1:0] a_out_sat;
    logic          b_in_ready, b_out_valid, b_out_last;
    logic [W-1:0]  b_out_data;
    logic [NL-1:0] b_out_sat;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    beats = 0;
    int    lasts = 0;
    int    ir_low_seen = 0;
    beat_t q[$];

    bias_add_relu_pipe #(.N_adder_tree(NL), .DATA_W(DW), .RELU_EN(1), .FRAME_BEATS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .bias(bias), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_sat(a_out_sat), .out_last(a_out_last));

    bias_add_relu_pipe #(.N_adder_tree(NL), .DATA_W(DW), .RELU_EN(0), .FRAME_BEATS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .bias(bias), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_sat(b_out_sat), .out_last(b_out_last));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [31:0]  v[4];
        logic [W-1:0] r;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = v[i][DW-1:0];
        return r;
    endfunction

    // Expected lane results straight from the arithmetic: clamp to the signed range, then ReLU.
    function automatic void model(input logic [W-1:0] s, input logic [W-1:0] b, input bit relu,
                                  output logic [W-1:0] d, output logic [NL-1:0] sat);
        d   = '0;
        sat = '0;
        for (int i = 0; i < NL; i++) begin
            logic signed [DW-1:0] sv;
            logic signed [DW-1:0] bv;
            int                   t;
            logic [31:0]          tv;
            sv = s[i*DW +: DW];
            bv = b[i*DW +: DW];
            t  = int'(sv) + int'(bv);
            if (t > MAXV) begin
                t = MAXV; sat[i] = 1'b1;
            end else if (t < MINV) begin
                t = MINV; sat[i] = 1'b1;
            end
            if (relu && t < 0) t = 0;
            tv = t;
            d[i*DW +: DW] = tv[DW-1:0];
        end
    endfunction

    task automatic monitor();
        logic [W-1:0]  ed;
        logic [NL-1:0] es;
        logic [W-1:0]  prev_data;
        bit            stalled_prev;
        bit            exp_ov;
        bit            exp_ir;
        stalled_prev = 1'b0;
        prev_data    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_out_valid_a", W'(a_out_valid), W'(0));
                chk("rst_out_data_a", a_out_data, W'(0));
                chk("rst_out_sat_a", W'(a_out_sat), W'(0));
                chk("rst_out_last_a", W'(a_out_last), W'(0));
                chk("rst_in_ready_a", W'(a_in_ready), W'(1));
                chk("rst_out_valid_b", W'(b_out_valid), W'(0));
                chk("rst_out_data_b", b_out_data, W'(0));
                q.delete();
                beats        = 0;
                lasts        = 0;
                stalled_prev = 1'b0;
            end else begin
                exp_ov = (q.size() >= 2) || (q.size() == 1 && (cyc - q[0].acc) >= 2);
                exp_ir = (q.size() < 2) || out_ready;
                chk("in_ready_a", W'(a_in_ready), W'(exp_ir));
                chk("in_ready_b", W'(b_in_ready), W'(exp_ir));
                chk("out_valid_a", W'(a_out_valid), W'(exp_ov));
                chk("out_valid_b", W'(b_out_valid), W'(exp_ov));
                if (a_out_valid && q.size() > 0) begin
                    model(q[0].s, q[0].b, 1'b1, ed, es);
                    chk("data_a", a_out_data, ed);
                    chk("sat_a", W'(a_out_sat), W'(es));
                    chk("last_a", W'(a_out_last), W'((beats % 4) == 3));
                    model(q[0].s, q[0].b, 1'b0, ed, es);
                    chk("data_b", b_out_data, ed);
                    chk("sat_b", W'(b_out_sat), W'(es));
                    chk("last_b", W'(b_out_last), W'(1));
                end else begin
                    chk("last_idle_a", W'(a_out_last), W'(0));
                end
                if (stalled_prev) chk("stable_a", a_out_data, prev_data);
                if (!a_in_ready) ir_low_seen++;
                stalled_prev = a_out_valid && !out_ready;
                prev_data    = a_out_data;
                if (a_out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    if (a_out_last) lasts++;
                    beats++;
                end
                if (in_valid && a_in_ready) q.push_back('{s: in_sum, b: bias, acc: cyc});
            end
        end
    endtask

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] b);
        bit acc;
        in_valid = 1'b1;
        in_sum   = s;
        bias     = b;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("send_timeout", W'(0), W'(1));
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !a_out_valid) return;
        end
        chk("drain_timeout", W'(0), W'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int ir0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        bias      = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beat latency: 100 + (-40) = 60
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sum   = pack4(100, 0, 0, 0);
        bias     = pack4(-40, 0, 0, 0);
        #1 chk("t1_in_ready", W'(a_in_ready), W'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t1_valid_t1", W'(a_out_valid), W'(0));
        @(posedge clk);
        #1;
        chk("t1_valid_t2", W'(a_out_valid), W'(1));
        chk("t1_lane0", W'(a_out_data[DW-1:0]), W'(60));
        chk("t1_sat", W'(a_out_sat), W'(0));
        wait_empty();

        // Overflow, underflow, ReLU and a plain lane side by side
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sum   = pack4(32'h1FFF0, 32'h20010, -5, 7);
        bias     = pack4(32'h00020, 32'h3FFE0, 2, -3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t2_data_relu", a_out_data, pack4(32'h1FFFF, 0, 0, 4));
        chk("t2_sat_relu", W'(a_out_sat), W'(4'b0011));
        chk("t2_data_norelu", b_out_data, pack4(32'h1FFFF, 32'h20000, 32'h3FFFD, 4));
        chk("t2_sat_norelu", W'(b_out_sat), W'(4'b0011));
        wait_empty();

        // Back-to-back beats with a 3-cycle stall mid-stream
        ir0 = ir_low_seen;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(pack4(k * 1000 + 1, -k, k, 3 * k), pack4(5, 6, 7, 8));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();
        chk("t4_in_ready_dropped", W'(ir_low_seen > ir0), W'(1));

        // Frame marking with random backpressure, counter starting from reset
        pulse_reset();
        fork
            begin
                for (int k = 0; k < 9; k++)
                    send(pack4(k * 20000 - 60000, k * 7, -k * 3, 131000), pack4(100, -50, 1, 1000));
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_empty();
        chk("t5_beats", W'(beats), W'(9));
        chk("t5_lasts", W'(lasts), W'(2));

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(pack4(11, 22, 33, 44), pack4(1, 1, 1, 1));
        send(pack4(55, 66, 77, 88), pack4(1, 1, 1, 1));
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("t6_full_in_ready", W'(a_in_ready), W'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid_a", W'(a_out_valid), W'(0));
        chk("t6_rst_data_a", a_out_data, W'(0));
        chk("t6_rst_valid_b", W'(b_out_valid), W'(0));
        chk("t6_rst_data_b", b_out_data, W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(pack4(k, -k, 2 * k, 9), pack4(3, 3, -20, 0));
        in_valid = 1'b0;
        wait_empty();
        chk("t6_beats", W'(beats), W'(4));
        chk("t6_lasts", W'(lasts), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
